// File: rtl/vote_tally_fsm_if.sv
// Handshake/bus bundle for the vote tally FSM.
// master drives start and vote buttons; slave is the tally block.
interface vote_tally_fsm_if #(
    parameter int N_VOTERS = 3,
    parameter int CNT_W    = 2
);
    logic                start;
    logic [N_VOTERS-1:0] vote_yes;
    logic [N_VOTERS-1:0] vote_no;
    logic                busy;
    logic [N_VOTERS-1:0] voted;
    logic [CNT_W-1:0]    yes_cnt;
    logic [CNT_W-1:0]    no_cnt;
    logic                pass;
    logic                fail;
    logic                result_valid;
    logic [1:0]          state;

    modport master (
        output start, vote_yes, vote_no,
        input  busy, voted, yes_cnt, no_cnt,
        input  pass, fail, result_valid, state
    );

    modport slave (
        input  start, vote_yes, vote_no,
        output busy, voted, yes_cnt, no_cnt,
        output pass, fail, result_valid, state
    );
endinterface

// File: rtl/vote_tally_fsm.sv
// Sequential vote tally: edge-detected yes/no votes per voter,
// round closes on all-voted or timeout, result held until next round.
module vote_tally_fsm #(
    parameter int N_VOTERS    = 3,
    parameter int CNT_W       = 2,
    parameter int THRESH      = 2,
    parameter int TIMEOUT_CYC = 16,
    parameter int TMR_W       = 4
) (
    input logic          clk100MHz,
    input logic          rst,
    vote_tally_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        SHOW    = 2'd3
    } state_e;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [N_VOTERS-1:0] yes_prev_q, no_prev_q;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CNT_W-1:0]    yes_cnt_q, yes_cnt_d;
    logic [CNT_W-1:0]    no_cnt_q, no_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                rv_q, rv_d;

    logic [N_VOTERS-1:0] yes_rise, no_rise;
    logic [N_VOTERS-1:0] yes_acc, no_acc;
    logic                ge;

    function automatic logic [CNT_W-1:0] popc(
        input logic [N_VOTERS-1:0] v
    );
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign yes_rise = bus.vote_yes & ~yes_prev_q;
    assign no_rise  = bus.vote_no & ~no_prev_q;
    // A simultaneous yes+no rise is ambiguous, so neither counts.
    assign yes_acc  = yes_rise & ~no_rise & ~voted_q;
    assign no_acc   = no_rise & ~yes_rise & ~voted_q;
    assign ge       = (int'(yes_cnt_q) >= THRESH);

    // State register.
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Tally, timer, result and edge-detect registers.
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            yes_prev_q <= '0;
            no_prev_q  <= '0;
            voted_q    <= '0;
            yes_cnt_q  <= '0;
            no_cnt_q   <= '0;
            timer_q    <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            yes_prev_q <= bus.vote_yes;
            no_prev_q  <= bus.vote_no;
            voted_q    <= voted_d;
            yes_cnt_q  <= yes_cnt_d;
            no_cnt_q   <= no_cnt_d;
            timer_q    <= timer_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            rv_q       <= rv_d;
        end
    end

    // Next-state and datapath updates per state.
    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        yes_cnt_d = yes_cnt_q;
        no_cnt_d  = no_cnt_q;
        timer_d   = timer_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        rv_d      = 1'b0;
        unique case (state_q)
            IDLE, SHOW: begin
                if (bus.start) begin
                    state_d   = COLLECT;
                    voted_d   = '0;
                    yes_cnt_d = '0;
                    no_cnt_d  = '0;
                    timer_d   = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            COLLECT: begin
                voted_d   = voted_q | yes_acc | no_acc;
                yes_cnt_d = yes_cnt_q + popc(yes_acc);
                no_cnt_d  = no_cnt_q + popc(no_acc);
                timer_d   = timer_q + 1'b1;
                if ((&voted_d) || (timer_q == TMO_LAST)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                state_d = SHOW;
                pass_d  = ge;
                fail_d  = ~ge;
                rv_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.state        = state_q;
    assign bus.busy         = (state_q == COLLECT) ||
                              (state_q == DECIDE);
    assign bus.voted        = voted_q;
    assign bus.yes_cnt      = yes_cnt_q;
    assign bus.no_cnt       = no_cnt_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_vote_tally_fsm.sv
// Bench for vote_tally_fsm: directed and random rounds
// against a per-voter behavioural model of the voting rules.
module tb_vote_tally_fsm;
    logic clk100MHz = 1'b0;
    logic rst;

    always #5 clk100MHz = ~clk100MHz;

    vote_tally_fsm_if #(.N_VOTERS(3), .CNT_W(2)) bus ();
    vote_tally_fsm_if #(.N_VOTERS(3), .CNT_W(2)) bus4 ();

    assign bus4.start    = bus.start;
    assign bus4.vote_yes = bus.vote_yes;
    assign bus4.vote_no  = bus.vote_no;

    vote_tally_fsm #(
        .N_VOTERS(3), .CNT_W(2), .THRESH(2),
        .TIMEOUT_CYC(16), .TMR_W(4)
    ) dut (
        .clk100MHz(clk100MHz),
        .rst(rst),
        .bus(bus.slave)
    );

    vote_tally_fsm #(
        .N_VOTERS(3), .CNT_W(2), .THRESH(4),
        .TIMEOUT_CYC(16), .TMR_W(4)
    ) dut4 (
        .clk100MHz(clk100MHz),
        .rst(rst),
        .bus(bus4.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] yw [0:40];
    logic [2:0] nw [0:40];
    logic       sw [0:40];

    function automatic logic [12:0] obs_main();
        return {bus.state, bus.busy, bus.voted,
                bus.yes_cnt, bus.no_cnt,
                bus.pass, bus.fail, bus.result_valid};
    endfunction

    function automatic logic [12:0] obs_th4();
        return {bus4.state, bus4.busy, bus4.voted,
                bus4.yes_cnt, bus4.no_cnt,
                bus4.pass, bus4.fail, bus4.result_valid};
    endfunction

    task automatic clear_waves();
        for (int k = 0; k <= 40; k++) begin
            yw[k] = 3'b000;
            nw[k] = 3'b000;
            sw[k] = 1'b0;
        end
    endtask

    // Opens a round with start, plays the waves on edges 1..40
    // and checks every cycle against the per-voter model.
    task automatic run_round(input string name);
        int         vk [3];
        logic       isy [3];
        int         close;
        int         ke;
        int         ey;
        int         en;
        int         fy;
        logic       all_v;
        logic       ry;
        logic       rn;
        logic [2:0] em;
        logic [1:0] es;
        logic [12:0] ov;
        logic [12:0] ev;
        begin
            close = 0;
            all_v = 1'b1;
            for (int v = 0; v < 3; v++) begin
                vk[v]  = 0;
                isy[v] = 1'b0;
                for (int k = 1; k <= 16; k++) begin
                    ry = yw[k][v] & ~yw[k-1][v];
                    rn = nw[k][v] & ~nw[k-1][v];
                    if (vk[v] == 0 && ry != rn) begin
                        vk[v]  = k;
                        isy[v] = ry;
                    end
                end
                if (vk[v] == 0) all_v = 1'b0;
                else if (vk[v] > close) close = vk[v];
            end
            if (!all_v) close = 16;
            fy = 0;
            for (int v = 0; v < 3; v++) begin
                if (vk[v] != 0 && isy[v]) fy++;
            end

            @(negedge clk100MHz);
            bus.start    = 1'b1;
            bus.vote_yes = 3'b000;
            bus.vote_no  = 3'b000;
            @(posedge clk100MHz);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk100MHz);
                bus.start    = sw[k];
                bus.vote_yes = yw[k];
                bus.vote_no  = nw[k];
                @(posedge clk100MHz);
                #1;
                ke = (k < close) ? k : close;
                ey = 0;
                en = 0;
                em = 3'b000;
                for (int v = 0; v < 3; v++) begin
                    if (vk[v] != 0 && vk[v] <= ke) begin
                        em[v] = 1'b1;
                        if (isy[v]) ey++;
                        else        en++;
                    end
                end
                es = (k < close) ? 2'd1 :
                     (k == close) ? 2'd2 : 2'd3;
                ev = {es, k <= close, em, 2'(ey), 2'(en),
                      (k > close) && (fy >= 2),
                      (k > close) && (fy < 2),
                      k == close + 1};
                ov = obs_main();
                n_chk++;
                if (ov !== ev) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got %b want %b",
                             name, k, ov, ev);
                end
            end
            bus.start    = 1'b0;
            bus.vote_yes = 3'b000;
            bus.vote_no  = 3'b000;
            n_chk++;
            if ({bus4.state, bus4.yes_cnt, bus4.pass, bus4.fail}
                !== {2'd3, 2'(fy), 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL %s thresh4: got %b want %b", name,
                         {bus4.state, bus4.yes_cnt, bus4.pass, bus4.fail},
                         {2'd3, 2'(fy), 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.vote_yes = 3'b000;
        bus.vote_no  = 3'b000;
        #2;
        n_chk++;
        if (obs_main() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset: got %b want 0", obs_main());
        end
        @(negedge clk100MHz);
        rst = 1'b0;
        @(posedge clk100MHz);
        #1;
        n_chk++;
        if (obs_th4() !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_idle4: got %b want 0", obs_th4());
        end
    endtask

    task automatic test_basic();
        clear_waves();
        yw[2] = 3'b001;
        yw[4] = 3'b010;
        nw[6] = 3'b100;
        run_round("basic");
    endtask

    task automatic test_timeout();
        clear_waves();
        for (int k = 1; k <= 10; k++) yw[k] = 3'b001;
        run_round("timeout");
    endtask

    task automatic test_simultaneous();
        clear_waves();
        yw[2] = 3'b001;
        nw[2] = 3'b001;
        nw[4] = 3'b001;
        yw[3] = 3'b110;
        run_round("simultaneous");
    endtask

    task automatic test_reset_mid();
        @(negedge clk100MHz);
        bus.start = 1'b1;
        @(posedge clk100MHz);
        @(negedge clk100MHz);
        bus.start    = 1'b0;
        bus.vote_yes = 3'b001;
        @(posedge clk100MHz);
        @(negedge clk100MHz);
        bus.vote_yes = 3'b000;
        @(posedge clk100MHz);
        #1;
        n_chk++;
        if ({bus.state, bus.yes_cnt} !== {2'd1, 2'd1}) begin
            n_fail++;
            $display("FAIL mid_pre: got %b want %b",
                     {bus.state, bus.yes_cnt}, {2'd1, 2'd1});
        end
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (obs_main() !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b want 0", obs_main());
        end
        @(negedge clk100MHz);
        rst = 1'b0;
    endtask

    task automatic test_start_ignored();
        clear_waves();
        sw[3] = 1'b1;
        sw[4] = 1'b1;
        yw[2] = 3'b001;
        nw[5] = 3'b010;
        yw[7] = 3'b100;
        run_round("start_ignored");
    endtask

    task automatic test_back_to_back();
        clear_waves();
        nw[1] = 3'b011;
        nw[3] = 3'b100;
        run_round("back_to_back");
    endtask

    task automatic test_repeat();
        clear_waves();
        yw[2] = 3'b001;
        yw[4] = 3'b001;
        yw[6] = 3'b001;
        nw[8] = 3'b011;
        yw[9] = 3'b100;
        run_round("repeat");
        clear_waves();
        yw[2] = 3'b111;
        run_round("all_yes");
    endtask

    task automatic test_random();
        int kind;
        int k;
        for (int r = 0; r < 20; r++) begin
            clear_waves();
            for (int v = 0; v < 3; v++) begin
                kind = $urandom_range(0, 4);
                k    = $urandom_range(1, 20);
                case (kind)
                    1: yw[k][v] = 1'b1;
                    2: begin
                        nw[k][v]   = 1'b1;
                        yw[k+2][v] = 1'b1;
                    end
                    3: begin
                        yw[k][v]   = 1'b1;
                        nw[k][v]   = 1'b1;
                        nw[k+2][v] = 1'b1;
                    end
                    4: begin
                        yw[k][v]   = 1'b1;
                        yw[k+2][v] = 1'b1;
                    end
                    default: ;
                endcase
            end
            run_round($sformatf("random%0d", r));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
